// File: rtl/ctrl_decode_stage.sv
// Registered RV32 control-decode stage: opcode classification, trap-hold FSM, flush, saturating illegal counter.
// Optional M-extension decode is enabled by defining CTRL_DECODE_MEXT_EN.
module ctrl_decode_stage #(
   parameter int ILEN      = 32,
   parameter int XLEN      = 32,
   parameter int ALUOP_W   = 4,
   parameter int ILL_CNT_W = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 flush_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [ILEN-1:0]      instr_i,
   input  logic [XLEN-1:0]      pc_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [ILEN-1:0]      out_instr_o,
   output logic [XLEN-1:0]      out_pc_o,
   output logic [ALUOP_W-1:0]   aluop_o,
   output logic                 reg_write_o,
   output logic                 mem_read_o,
   output logic                 mem_write_o,
   output logic                 branch_o,
   output logic                 jump_o,
   output logic                 alu_src_b_o,
   output logic                 mem_to_reg_o,
   output logic                 illegal_o,
   output logic                 trap_o,
   input  logic                 trap_ack_i,
   output logic [ILL_CNT_W-1:0] ill_count_o,
   output logic                 dbg_state_o
);

   // Handshake: a transfer happens on a side in any cycle where its valid and ready are both 1.
   // The output entry is held stable while out_valid_o=1 and out_ready_i=0.
   typedef enum logic {RUN = 1'b0, TRAP = 1'b1} state_t;

   state_t state;

   logic [ALUOP_W-1:0] d_aluop;
   logic d_reg_write, d_mem_read, d_mem_write, d_branch, d_jump;
   logic d_alu_src_b, d_mem_to_reg, d_illegal;
   logic accept;

   assign in_ready_o  = (state == RUN) & ~flush_i & (~out_valid_o | out_ready_i);
   assign accept      = in_valid_i & in_ready_o;
   assign trap_o      = (state == TRAP);
   assign dbg_state_o = state;

   always_comb begin
      d_aluop      = '0;
      d_reg_write  = 1'b0;
      d_mem_read   = 1'b0;
      d_mem_write  = 1'b0;
      d_branch     = 1'b0;
      d_jump       = 1'b0;
      d_alu_src_b  = 1'b0;
      d_mem_to_reg = 1'b0;
      d_illegal    = 1'b0;
      case (instr_i[6:0])
         7'b0110011: begin
            d_reg_write = 1'b1;
            if (instr_i[31:25] == 7'b0000000 || instr_i[31:25] == 7'b0100000)
               d_aluop = ALUOP_W'(4'b0000);
`ifdef CTRL_DECODE_MEXT_EN
            else if (instr_i[31:25] == 7'b0000001)
               d_aluop = ALUOP_W'(4'b1000);
`endif
            else
               d_illegal = 1'b1;
         end
         7'b0010011: begin d_aluop = ALUOP_W'(4'b0001); d_reg_write = 1'b1; d_alu_src_b = 1'b1; end
         7'b1100011: begin d_aluop = ALUOP_W'(4'b0010); d_branch = 1'b1; end
         7'b1100111: begin
            d_aluop = ALUOP_W'(4'b0011); d_jump = 1'b1; d_reg_write = 1'b1; d_alu_src_b = 1'b1;
         end
         7'b1101111: begin d_aluop = ALUOP_W'(4'b0011); d_jump = 1'b1; d_reg_write = 1'b1; end
         7'b0000011: begin
            d_aluop = ALUOP_W'(4'b0100); d_reg_write = 1'b1; d_mem_read = 1'b1;
            d_alu_src_b = 1'b1; d_mem_to_reg = 1'b1;
         end
         7'b0100011: begin d_aluop = ALUOP_W'(4'b0101); d_mem_write = 1'b1; d_alu_src_b = 1'b1; end
         7'b0110111: begin d_aluop = ALUOP_W'(4'b0110); d_reg_write = 1'b1; d_alu_src_b = 1'b1; end
         7'b0010111: begin d_aluop = ALUOP_W'(4'b0111); d_reg_write = 1'b1; d_alu_src_b = 1'b1; end
         default:    d_illegal = 1'b1;
      endcase
      // Every listed opcode ends in 11, so compressed encodings already fall to default.
      if (d_illegal) begin
         d_aluop      = {ALUOP_W{1'b1}};
         d_reg_write  = 1'b0;
         d_mem_read   = 1'b0;
         d_mem_write  = 1'b0;
         d_branch     = 1'b0;
         d_jump       = 1'b0;
         d_alu_src_b  = 1'b0;
         d_mem_to_reg = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= RUN;
         out_valid_o  <= 1'b0;
         out_instr_o  <= '0;
         out_pc_o     <= '0;
         aluop_o      <= '0;
         reg_write_o  <= 1'b0;
         mem_read_o   <= 1'b0;
         mem_write_o  <= 1'b0;
         branch_o     <= 1'b0;
         jump_o       <= 1'b0;
         alu_src_b_o  <= 1'b0;
         mem_to_reg_o <= 1'b0;
         illegal_o    <= 1'b0;
         ill_count_o  <= '0;
      end else if (flush_i) begin
         state       <= RUN;
         out_valid_o <= 1'b0;
      end else begin
         if (state == TRAP && trap_ack_i)
            state <= RUN;
         if (accept) begin
            out_valid_o  <= 1'b1;
            out_instr_o  <= instr_i;
            out_pc_o     <= pc_i;
            aluop_o      <= d_aluop;
            reg_write_o  <= d_reg_write;
            mem_read_o   <= d_mem_read;
            mem_write_o  <= d_mem_write;
            branch_o     <= d_branch;
            jump_o       <= d_jump;
            alu_src_b_o  <= d_alu_src_b;
            mem_to_reg_o <= d_mem_to_reg;
            illegal_o    <= d_illegal;
            if (d_illegal) begin
               state <= TRAP;
               if (ill_count_o != {ILL_CNT_W{1'b1}})
                  ill_count_o <= ill_count_o + 1'b1;
            end
         end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
         end
      end
   end

endmodule
